// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v counters with region decode,
// registered syncs and active-area flag, plus per-frame start and divided game tick.
module vga_timing_gen #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   FRAME_DIV = 12,
    parameter int   X_W       = 10,
    parameter int   Y_W       = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    output logic           pix_en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     hstate,
    output logic [1:0]     vstate,
    output logic           hsync,
    output logic           vsync,
    output logic           display,
    output logic           frame_start,
    output logic           frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FCNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_DIV - 1);

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_FP_START = X_W'(H_DISPLAY);
    localparam logic [X_W-1:0] H_SY_START = X_W'(H_DISPLAY + H_FRONT);
    localparam logic [X_W-1:0] H_BP_START = X_W'(H_DISPLAY + H_FRONT + H_SYNC);

    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_FP_START = Y_W'(V_DISPLAY);
    localparam logic [Y_W-1:0] V_SY_START = Y_W'(V_DISPLAY + V_FRONT);
    localparam logic [Y_W-1:0] V_BP_START = Y_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]  div_q,       div_d;
    logic [X_W-1:0]    h_cnt_q,     h_cnt_d;
    logic [Y_W-1:0]    v_cnt_q,     v_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              hsync_q,       hsync_d;
    logic              vsync_q,       vsync_d;
    logic              display_q,     display_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_tick_q,  frame_tick_d;

    logic h_last;
    logic v_last;
    logic frame_last;
    logic frame_wrap;

    assign pix_en     = enable && (div_q == DIV_LAST);
    assign h_last     = (h_cnt_q == H_LAST);
    assign v_last     = (v_cnt_q == V_LAST);
    assign frame_last = (frame_cnt_q == FRAME_LAST);
    assign frame_wrap = pix_en && h_last && v_last;

    // Region decode: 0 active, 1 front porch, 2 sync, 3 back porch.
    always_comb begin
        if (h_cnt_q < H_FP_START) begin
            hstate = 2'd0;
        end else if (h_cnt_q < H_SY_START) begin
            hstate = 2'd1;
        end else if (h_cnt_q < H_BP_START) begin
            hstate = 2'd2;
        end else begin
            hstate = 2'd3;
        end
    end

    always_comb begin
        if (v_cnt_q < V_FP_START) begin
            vstate = 2'd0;
        end else if (v_cnt_q < V_SY_START) begin
            vstate = 2'd1;
        end else if (v_cnt_q < V_BP_START) begin
            vstate = 2'd2;
        end else begin
            vstate = 2'd3;
        end
    end

    always_comb begin
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        display_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_tick_d  = 1'b0;

        if (!enable) begin
            // Idle: park at the origin so re-enable starts a fresh frame.
            div_d       = '0;
            h_cnt_d     = '0;
            v_cnt_d     = '0;
            frame_cnt_d = '0;
        end else begin
            div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            hsync_d   = (hstate == 2'd2) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d   = (vstate == 2'd2) ? VSYNC_POL : ~VSYNC_POL;
            display_d = (hstate == 2'd0) && (vstate == 2'd0);

            if (pix_en) begin
                if (h_last) begin
                    h_cnt_d = '0;
                    v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end

            frame_start_d = frame_wrap;
            frame_tick_d  = frame_wrap && frame_last;
            if (frame_wrap) begin
                frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            frame_start_q <= frame_start_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display     = display_q;
    assign frame_start = frame_start_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three rasters driven in lockstep, per-clock expectations
// from an arithmetic raster model queued at drive time and checked after the edge.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] hs;
        logic [1:0] vs;
        logic       pe;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       fs;
        logic       ft;
    } obs_t;

    typedef struct {
        int   d;
        int   hd, hf, hsw, hb;
        int   vd, vf, vsw, vb;
        int   fd;
        logic hpol, vpol;
    } cfg_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    // Small raster, CLK_DIV=2, active-low syncs
    logic       pe_s, hsync_s, vsync_s, disp_s, fs_s, ft_s;
    logic [9:0] x_s, y_s;
    logic [1:0] hs_s, vs_s;
    // Small raster, CLK_DIV=1, active-high syncs
    logic       pe_p, hsync_p, vsync_p, disp_p, fs_p, ft_p;
    logic [9:0] x_p, y_p;
    logic [1:0] hs_p, vs_p;
    // Default 640x480 raster
    logic       pe_d, hsync_d, vsync_d, disp_d, fs_d, ft_d;
    logic [9:0] x_d, y_d;
    logic [1:0] hs_d, vs_d;

    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_DIV(3), .X_W(10), .Y_W(10)
    ) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .pix_en(pe_s), .x(x_s), .y(y_s),
        .hstate(hs_s), .vstate(vs_s), .hsync(hsync_s), .vsync(vsync_s),
        .display(disp_s), .frame_start(fs_s), .frame_tick(ft_s)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FRAME_DIV(2), .X_W(10), .Y_W(10)
    ) dut_p (
        .clk(clk), .reset(reset), .enable(enable), .pix_en(pe_p), .x(x_p), .y(y_p),
        .hstate(hs_p), .vstate(vs_p), .hsync(hsync_p), .vsync(vsync_p),
        .display(disp_p), .frame_start(fs_p), .frame_tick(ft_p)
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .enable(enable), .pix_en(pe_d), .x(x_d), .y(y_d),
        .hstate(hs_d), .vstate(vs_d), .hsync(hsync_d), .vsync(vsync_d),
        .display(disp_d), .frame_start(fs_d), .frame_tick(ft_d)
    );

    cfg_t cs, cp, cd;
    obs_t q_s[$];
    obs_t q_p[$];
    obs_t q_d[$];

    int checks = 0;
    int errors = 0;
    int n = 0;
    int cyc = 0;
    int last_fs = 0;
    int fs_cnt = 0;
    int ft_cnt = 0;
    int hs_low_d = 0;

    function automatic logic [1:0] rgn(input int c, input int disp, input int fr, input int sy);
        if (c < disp) return 2'd0;
        if (c < disp + fr) return 2'd1;
        if (c < disp + fr + sy) return 2'd2;
        return 2'd3;
    endfunction

    // n = enabled clock edges since the generator last sat idle at the origin.
    function automatic obs_t model(input int cnt, input logic en, input cfg_t c);
        obs_t o;
        int ht, vt, p, pp, dv, hc, vc, hpc, vpc;
        ht = c.hd + c.hf + c.hsw + c.hb;
        vt = c.vd + c.vf + c.vsw + c.vb;
        o = '0;
        o.hsync = ~c.hpol;
        o.vsync = ~c.vpol;
        if (cnt == 0) begin
            o.pe = en && (c.d == 1);
            return o;
        end
        dv  = cnt % c.d;
        p   = cnt / c.d;
        hc  = p % ht;
        vc  = (p / ht) % vt;
        pp  = (cnt - 1) / c.d;
        hpc = pp % ht;
        vpc = (pp / ht) % vt;
        o.x     = 10'(hc);
        o.y     = 10'(vc);
        o.hs    = rgn(hc, c.hd, c.hf, c.hsw);
        o.vs    = rgn(vc, c.vd, c.vf, c.vsw);
        o.pe    = (dv == c.d - 1);
        o.hsync = (rgn(hpc, c.hd, c.hf, c.hsw) == 2'd2) ? c.hpol : ~c.hpol;
        o.vsync = (rgn(vpc, c.vd, c.vf, c.vsw) == 2'd2) ? c.vpol : ~c.vpol;
        o.disp  = (rgn(hpc, c.hd, c.hf, c.hsw) == 2'd0) && (rgn(vpc, c.vd, c.vf, c.vsw) == 2'd0);
        o.fs    = (dv == 0) && (p % (ht * vt) == 0);
        o.ft    = o.fs && ((p / (ht * vt)) % c.fd == 0);
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got x=%0d y=%0d hs=%0d vs=%0d pe=%b hsy=%b vsy=%b disp=%b fs=%b ft=%b exp x=%0d y=%0d hs=%0d vs=%0d pe=%b hsy=%b vsy=%b disp=%b fs=%b ft=%b",
                   tag, cyc, got.x, got.y, got.hs, got.vs, got.pe, got.hsync, got.vsync, got.disp, got.fs, got.ft,
                   exp.x, exp.y, exp.hs, exp.vs, exp.pe, exp.hsync, exp.vsync, exp.disp, exp.fs, exp.ft);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic push_all(input logic en);
        q_s.push_back(model(n, en, cs));
        q_p.push_back(model(n, en, cp));
        q_d.push_back(model(n, en, cd));
    endtask

    task automatic pop_check_all();
        obs_t gs, gp, gd;
        gs = '{x_s, y_s, hs_s, vs_s, pe_s, hsync_s, vsync_s, disp_s, fs_s, ft_s};
        gp = '{x_p, y_p, hs_p, vs_p, pe_p, hsync_p, vsync_p, disp_p, fs_p, ft_p};
        gd = '{x_d, y_d, hs_d, vs_d, pe_d, hsync_d, vsync_d, disp_d, fs_d, ft_d};
        check_obs("small_div2", gs, q_s.pop_front());
        check_obs("small_div1_pol1", gp, q_p.pop_front());
        check_obs("default", gd, q_d.pop_front());
    endtask

    task automatic step(input logic en);
        @(negedge clk);
        enable = en;
        n = en ? n + 1 : 0;
        cyc++;
        push_all(en);
        @(posedge clk);
        #1;
        pop_check_all();
        if (!en) last_fs = cyc;
        if (fs_s) begin
            fs_cnt++;
            check_int("fs_period", cyc - last_fs, 96);
            last_fs = cyc;
        end
        if (ft_s) begin
            ft_cnt++;
            check_int("ft_with_fs", int'(fs_s), 1);
        end
        if (!hsync_d) hs_low_d++;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cs = '{2, 4, 1, 2, 1, 3, 1, 1, 1, 3, 1'b0, 1'b0};
        cp = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 2, 1'b1, 1'b1};
        cd = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 12, 1'b0, 1'b0};

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        push_all(1'b0);
        pop_check_all();
        last_fs = cyc;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Nine small frames: frame_start every 96 clocks, frame_tick every third one
        fs_cnt = 0;
        ft_cnt = 0;
        for (int i = 0; i < 9 * 96; i++) step(1'b1);
        check_int("fs_count_9_frames", fs_cnt, 9);
        check_int("ft_count_9_frames", ft_cnt, 3);

        // Drop enable at x=5, y=2 for three clocks, then run past the next frame start
        for (int i = 0; i < 200; i++) begin
            obs_t m;
            m = model(n, 1'b1, cs);
            if (m.x == 10'd5 && m.y == 10'd2) break;
            step(1'b1);
        end
        check_int("reached_x5_y2", int'(x_s == 10'd5 && y_s == 10'd2), 1);
        fs_cnt = 0;
        repeat (3) step(1'b0);
        for (int i = 0; i < 100; i++) step(1'b1);
        check_int("fs_after_reenable", fs_cnt, 1);

        // Asynchronous reset mid-line: outputs take reset values without a clock edge
        repeat (3) step(1'b1);
        #3;
        reset = 1'b0;
        #1;
        n = 0;
        push_all(1'b1);
        pop_check_all();
        last_fs = cyc;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // One full default line: 1600 clocks, hsync low for 192 of them
        hs_low_d = 0;
        for (int i = 0; i < 1600; i++) step(1'b1);
        check_int("default_hsync_low_clocks", hs_low_d, 192);
        check_int("default_line_wrap_x", int'(x_d), 0);
        check_int("default_line_wrap_y", int'(y_d), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
